best_candidates_reader: RTL and testbench
=========================================

Name: best_candidates_reader

Overview:
- Parallel-in, serial-out reader for the FME best-candidate buffer.
- Captures all 8 candidate lanes at the buffer output in one handshake, then streams them one per beat, lane 0 first, to the downstream refinement/cost stage.
- Each beat carries a lane index and a last flag; valid/ready on both sides lets the consumer stall.

Parameters:
- DATAWIDTH, 8, bit width of each candidate lane and of out_data.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- load_valid  input  1  all 8 lanes on in_0..in_7 are valid this cycle.
- load_ready  output  1  block accepts a load this cycle.
- in_0 .. in_7  input  DATAWIDTH each  candidate lanes 0..7, sampled only on load handshake.
- out_data  output  DATAWIDTH  current candidate.
- out_index  output  3  lane number of out_data.
- out_last  output  1  high on the lane-7 beat.
- out_valid  output  1  out_data/out_index/out_last are valid.
- out_ready  input  1  consumer accepts the current beat.
- frame_done  output  1  one-cycle pulse after the lane-7 beat is accepted.

Behaviour:
- Reset (reset=0, async): state IDLE; shadow lanes, out_data, out_index, out_last, out_valid, frame_done all 0; load_ready forced 0 while reset=0.
- Load handshake: load_valid & load_ready on a rising edge. Out beat handshake: out_valid & out_ready on a rising edge.
- States: IDLE, STREAM.
- IDLE:
  - load_ready=1, out_valid=0.
  - On a load handshake, capture in_0..in_7 into 8 shadow registers and go to STREAM.
  - Next cycle: out_valid=1, out_index=0, out_data=lane0. One cycle of latency from load to first beat.
- STREAM:
  - out_data = shadow[out_index]; out_last = (out_index==7).
  - While out_valid & !out_ready: out_data, out_index and out_last stay stable, and the shadow registers do not change.
  - On a beat handshake with out_index<7: out_index increments by 1 and the next lane appears the following cycle.
  - On the lane-7 beat handshake: frame_done=1 for the next cycle.
- load_ready in STREAM:
  - load_ready = out_valid & out_ready & out_last, combinational from out_ready.
  - It may only be high on the final beat.
- Lane-7 beat accepted together with a load handshake:
  - The new lanes are captured and the block stays in STREAM.
  - Next cycle: out_index=0 with the new lane0. No bubble between frames.
- Lane-7 beat accepted with no load: go to IDLE; out_valid=0 the next cycle.
- Blocked loads: load_valid during STREAM before the final beat is not accepted, and the upstream holds its lanes. Lane inputs are ignored at all times except on a load handshake.
- out_index never exceeds 7 and does not wrap past 7 inside a frame. It returns to 0 only on a new load.
- Reset asserted mid-frame: the frame is aborted immediately and all outputs go to their reset values. Nothing is streamed after reset releases until a new load.
- frame_done is registered; it is never high in the same cycle as out_valid for that same frame's beat.
- Throughput: 8 beats per frame at out_ready=1, continuous across frames.

Test Plan:
- Reset, then load in_k = 8'h10+k with out_ready=1 -> load accepted in cycle 0; cycles 1..8 give out_index 0..7 and out_data 8'h10..8'h17; out_last only in cycle 8; frame_done in cycle 9; out_valid=0 in cycle 9.
- Same load, out_ready toggling 1,0,0,1,... -> each beat held stable while out_ready=0; the sequence is still 8'h10..8'h17 with no repeat or skip.
- Frame A (8'hA0..A7) streaming with load_valid held high carrying frame B (8'hB0..B7) -> load_ready high only on the lane-7 beat; beat 8'hB0 follows 8'hA7 on the next cycle; 16 beats in 16 cycles.
- in_k changed every cycle during STREAM -> output still shows the captured values.
- Reset asserted (reset=0) mid-frame at out_index=3 -> out_valid, out_index, out_data, frame_done and load_ready drop to 0 asynchronously, before the next edge. After release: load_ready=1 and no beats until a new load.
- load_valid=1 in IDLE with out_ready held 0 -> load accepted; lane0 stays presented indefinitely with load_ready=0; when out_ready rises, streaming resumes normally.

Source files
------------

// File: rtl/best_candidates_reader.sv
// rtl/best_candidates_reader.sv - captures 8 candidate lanes in one load, streams them lane 0..7
// Shadow copy decouples the buffer from the consumer; the final beat may overlap the next load.
module best_candidates_reader #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [DATAWIDTH-1:0] in_0,
    input  logic [DATAWIDTH-1:0] in_1,
    input  logic [DATAWIDTH-1:0] in_2,
    input  logic [DATAWIDTH-1:0] in_3,
    input  logic [DATAWIDTH-1:0] in_4,
    input  logic [DATAWIDTH-1:0] in_5,
    input  logic [DATAWIDTH-1:0] in_6,
    input  logic [DATAWIDTH-1:0] in_7,
    output logic [DATAWIDTH-1:0] out_data,
    output logic [2:0]           out_index,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 frame_done
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] shadow_q [8];
    logic [DATAWIDTH-1:0] shadow_d [8];
    logic [DATAWIDTH-1:0] lanes    [8];
    logic [2:0]           idx_q, idx_d;
    logic                 frame_done_q, frame_done_d;
    logic                 load_hs, beat_hs;

    assign lanes[0] = in_0;
    assign lanes[1] = in_1;
    assign lanes[2] = in_2;
    assign lanes[3] = in_3;
    assign lanes[4] = in_4;
    assign lanes[5] = in_5;
    assign lanes[6] = in_6;
    assign lanes[7] = in_7;

    assign out_valid  = (state_q == STREAM);
    assign out_index  = idx_q;
    assign out_data   = shadow_q[idx_q];
    assign out_last   = out_valid && (idx_q == 3'd7);
    assign frame_done = frame_done_q;

    // A new frame may only be taken while idle or as the last beat leaves.
    assign load_ready = reset && ((state_q == IDLE) || (out_valid && out_ready && out_last));
    assign load_hs    = load_valid && load_ready;
    assign beat_hs    = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_hs) begin
                    shadow_d = lanes;
                    idx_d    = 3'd0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (beat_hs) begin
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        frame_done_d = 1'b1;
                        if (load_hs) begin
                            shadow_d = lanes;
                            idx_d    = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            frame_done_q <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            shadow_q     <= shadow_d;
        end
    end

endmodule

// File: tb/tb_best_candidates_reader.sv
// tb/tb_best_candidates_reader.sv - directed and random checks against a beat-queue model
module tb_best_candidates_reader;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       load_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [7:0] lanes [8];
    logic       load_ready, out_last, out_valid, frame_done;
    logic [7:0] out_data;
    logic [2:0] out_index;

    int passed = 0;
    int total  = 0;

    // Model: the beats still owed to the consumer, front = currently presented.
    logic [7:0] q_data [$];
    int         q_idx  [$];
    bit         exp_fd = 1'b0;

    always #5 clock = ~clock;

    best_candidates_reader #(.DATAWIDTH(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .in_0       (lanes[0]),
        .in_1       (lanes[1]),
        .in_2       (lanes[2]),
        .in_3       (lanes[3]),
        .in_4       (lanes[4]),
        .in_5       (lanes[5]),
        .in_6       (lanes[6]),
        .in_7       (lanes[7]),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_lanes(input logic [7:0] base);
        for (int k = 0; k < 8; k++) lanes[k] = base + 8'(k);
    endtask

    task automatic rand_lanes();
        for (int k = 0; k < 8; k++) lanes[k] = 8'($urandom);
    endtask

    // Check outputs at the falling edge, then advance the model across the rising edge.
    task automatic step();
        bit         exp_valid, exp_lr, lhs, bhs, pop7;
        logic [7:0] snap [8];
        @(negedge clock);
        exp_valid = (q_data.size() != 0);
        exp_lr    = reset && ((q_data.size() == 0) || (q_data.size() == 1 && out_ready));
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("load_ready", 32'(load_ready), 32'(exp_lr));
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
        if (exp_valid) begin
            chk("out_data", 32'(out_data), 32'(q_data[0]));
            chk("out_index", 32'(out_index), 32'(q_idx[0]));
            chk("out_last", 32'(out_last), 32'(q_idx[0] == 7));
        end else begin
            chk("out_last_idle", 32'(out_last), 32'(0));
        end
        lhs  = load_valid && exp_lr;
        bhs  = exp_valid && out_ready;
        pop7 = bhs && (q_idx[0] == 7);
        snap = lanes;
        @(posedge clock);
        if (bhs) begin
            void'(q_data.pop_front());
            void'(q_idx.pop_front());
        end
        if (lhs) begin
            for (int k = 0; k < 8; k++) begin
                q_data.push_back(snap[k]);
                q_idx.push_back(k);
            end
        end
        exp_fd = pop7;
        #1;
    endtask

    initial begin
        set_lanes(8'h00);
        #1;
        chk("rst_valid", 32'(out_valid), 32'(0));
        chk("rst_load_ready", 32'(load_ready), 32'(0));
        chk("rst_data", 32'(out_data), 32'(0));
        chk("rst_index", 32'(out_index), 32'(0));
        chk("rst_frame_done", 32'(frame_done), 32'(0));
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Single frame at full rate.
        set_lanes(8'h10);
        load_valid = 1'b1;
        out_ready  = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (10) step();

        // Consumer stalls while lane inputs churn.
        set_lanes(8'h10);
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 26; i++) begin
            out_ready = (i % 3 == 0);
            rand_lanes();
            step();
        end
        out_ready = 1'b1;
        repeat (4) step();

        // Back-to-back frames with load held across frame A.
        set_lanes(8'hA0);
        load_valid = 1'b1;
        step();
        set_lanes(8'hB0);
        repeat (8) step();
        load_valid = 1'b0;
        repeat (10) step();

        // Reset in the middle of a frame.
        rand_lanes();
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (3) step();
        chk("pre_reset_index", 32'(out_index), 32'(3));
        reset = 1'b0;
        #1;
        chk("abort_valid", 32'(out_valid), 32'(0));
        chk("abort_index", 32'(out_index), 32'(0));
        chk("abort_data", 32'(out_data), 32'(0));
        chk("abort_frame_done", 32'(frame_done), 32'(0));
        chk("abort_load_ready", 32'(load_ready), 32'(0));
        q_data.delete();
        q_idx.delete();
        exp_fd = 1'b0;
        step();
        reset = 1'b1;
        #1;
        chk("release_load_ready", 32'(load_ready), 32'(1));
        repeat (3) step();

        // Load with the consumer stalled indefinitely, then released.
        set_lanes(8'h50);
        load_valid = 1'b1;
        out_ready  = 1'b0;
        step();
        load_valid = 1'b0;
        repeat (12) step();
        out_ready = 1'b1;
        repeat (10) step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            load_valid = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            rand_lanes();
            step();
        end
        load_valid = 1'b0;
        out_ready  = 1'b1;
        repeat (10) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
